// File: rtl/bsg_manycore_link_sif_injector.sv
// bsg_manycore_link_sif_injector
//
// Manycore network endpoint that originates forward request packets from a
// local client and absorbs the matching return packets (credits or read data).
// It sits at the edge of the array, typically under a test harness or a host
// bridge, and is the active counterpart of a tied-off link_sif port.
//
// Ports:
//   clk_i               clock
//   reset_i             synchronous reset, active-high
//   link_sif_i          network-to-endpoint link bundle
//   link_sif_o          endpoint-to-network link bundle
//   pkt_v_i             client request valid
//   pkt_i               client request packet
//   pkt_ready_o         request accepted when pkt_v_i & pkt_ready_o
//   returned_v_o        one-cycle pulse: a return packet was absorbed last cycle
//   returned_data_o     data field of that return packet (held between pulses)
//   returned_pkt_type_o pkt_type field of that return packet (held between pulses)
//   out_credits_o       credits currently available for new requests
//   idle_o              no requests outstanding
//   error_o             sticky: a return arrived with no request outstanding
//   timeout_o           sticky watchdog flag (only with the macro below)
//
// Optional feature macro: BSG_MANYCORE_INJECTOR_TIMEOUT_EN
//   When defined, a watchdog counts cycles spent waiting for returns while
//   requests are outstanding and raises timeout_o after timeout_p cycles
//   without any return.
//
// Link layout (MSB first): {fwd.v, fwd.data, fwd.ready_and_rev,
//                           rev.v, rev.data, rev.ready_and_rev}
// Return packet layout (MSB first): {pkt_type, data, reg_id, y_cord, x_cord}
//
// x_cord_width_p / y_cord_width_p have no meaningful default; instantiators
// are expected to set them to match the mesh.

module bsg_manycore_link_sif_injector #(
    parameter int addr_width_p      = 32,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int max_out_credits_p = 16,
    parameter int timeout_p         = 1024,
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1),
    localparam int return_width_lp  = 2 + data_width_p + 5 + y_cord_width_p + x_cord_width_p,
    localparam int packet_width_lp  = addr_width_p + 2 + 4 + 5 + data_width_p
                                      + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int link_sif_width_lp = (packet_width_lp + 2) + (return_width_lp + 2)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic [link_sif_width_lp-1:0] link_sif_i,
    output logic [link_sif_width_lp-1:0] link_sif_o,

    input  logic                         pkt_v_i,
    input  logic [packet_width_lp-1:0]   pkt_i,
    output logic                         pkt_ready_o,

    output logic                         returned_v_o,
    output logic [data_width_p-1:0]      returned_data_o,
    output logic [1:0]                   returned_pkt_type_o,

    output logic [credit_width_lp-1:0]   out_credits_o,
    output logic                         idle_o,
    output logic                         error_o
`ifdef BSG_MANYCORE_INJECTOR_TIMEOUT_EN
    ,output logic                        timeout_o
`endif
);

    typedef struct packed {
        logic [addr_width_p-1:0]   addr;
        logic [1:0]                op;
        logic [3:0]                op_ex;
        logic [4:0]                reg_id;
        logic [data_width_p-1:0]   payload;
        logic [y_cord_width_p-1:0] src_y_cord;
        logic [x_cord_width_p-1:0] src_x_cord;
        logic [y_cord_width_p-1:0] y_cord;
        logic [x_cord_width_p-1:0] x_cord;
    } packet_s;

    typedef struct packed {
        logic [1:0]                pkt_type;
        logic [data_width_p-1:0]   data;
        logic [4:0]                reg_id;
        logic [y_cord_width_p-1:0] y_cord;
        logic [x_cord_width_p-1:0] x_cord;
    } return_packet_s;

    typedef struct packed {
        logic    v;
        packet_s data;
        logic    ready_and_rev;
    } fwd_link_sif_s;

    typedef struct packed {
        logic           v;
        return_packet_s data;
        logic           ready_and_rev;
    } rev_link_sif_s;

    typedef struct packed {
        fwd_link_sif_s fwd;
        rev_link_sif_s rev;
    } link_sif_s;

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    link_sif_s                  link_in;
    link_sif_s                  link_out;
    logic [credit_width_lp-1:0] credits_r;
    logic                       error_r;
    logic                       returned_v_r;
    logic [data_width_p-1:0]    returned_data_r;
    logic [1:0]                 returned_pkt_type_r;
    logic                       have_credit;
    logic                       fwd_v;
    logic                       send;
    logic                       receive;
    logic                       unused_link_bits;

    assign link_in    = link_sif_i;
    assign link_sif_o = link_out;

    // Fields of the incoming bundle this endpoint never looks at: it serves no
    // forward requests and does not need the routing fields of return packets.
    assign unused_link_bits = ^{link_in.fwd.v, link_in.fwd.data, link_in.rev.ready_and_rev,
                                link_in.rev.data.reg_id, link_in.rev.data.y_cord,
                                link_in.rev.data.x_cord};

    // Client-to-network path is purely combinational. Gating valid on a
    // non-zero credit count is what keeps the counter from ever underflowing.
    assign have_credit = (credits_r != '0);
    assign fwd_v       = pkt_v_i & have_credit & ~reset_i;
    assign pkt_ready_o = link_in.fwd.ready_and_rev & have_credit & ~reset_i;
    assign send        = fwd_v & link_in.fwd.ready_and_rev;
    assign receive     = link_in.rev.v & ~reset_i;

    // Outgoing bundle: forward carries the client packet, incoming requests
    // are never accepted and no responses are produced, and returns are
    // always absorbed except while in reset.
    always_comb begin
        link_out                   = '0;
        link_out.fwd.v             = fwd_v;
        link_out.fwd.data          = pkt_i;
        link_out.rev.ready_and_rev = ~reset_i;
    end

    // Credit counter and sticky error. A return with every credit already
    // home (and no send to balance it) is a protocol violation: the counter
    // saturates instead of wrapping and the error flag latches.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_r <= max_credits_lp;
            error_r   <= 1'b0;
        end else begin
            case ({send, receive})
                2'b10: credits_r <= credits_r - credit_width_lp'(1);
                2'b01: begin
                    if (credits_r == max_credits_lp) begin
                        error_r <= 1'b1;
                    end else begin
                        credits_r <= credits_r + credit_width_lp'(1);
                    end
                end
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Registered capture of each absorbed return packet; data and type hold
    // their last value between pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            returned_v_r        <= 1'b0;
            returned_data_r     <= '0;
            returned_pkt_type_r <= '0;
        end else begin
            returned_v_r <= receive;
            if (receive) begin
                returned_data_r     <= link_in.rev.data.data;
                returned_pkt_type_r <= link_in.rev.data.pkt_type;
            end
        end
    end

    assign out_credits_o       = credits_r;
    assign idle_o              = (credits_r == max_credits_lp);
    assign error_o             = error_r;
    assign returned_v_o        = returned_v_r;
    assign returned_data_o     = returned_data_r;
    assign returned_pkt_type_o = returned_pkt_type_r;

`ifdef BSG_MANYCORE_INJECTOR_TIMEOUT_EN
    localparam int wd_width_lp = (timeout_p + 1 <= 1) ? 1 : $clog2(timeout_p + 1);
    localparam logic [wd_width_lp-1:0] wd_limit_lp = wd_width_lp'(timeout_p);

    logic [wd_width_lp-1:0] wd_r;
    logic                   timeout_r;

    // Watchdog: counts cycles with requests outstanding and no return
    // arriving. Any return, or going idle, restarts it; it saturates at the
    // limit so the flag stays asserted without wrapping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_r      <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (receive || idle_o) begin
                wd_r <= '0;
            end else if (wd_r != wd_limit_lp) begin
                wd_r <= wd_r + wd_width_lp'(1);
            end
            if (wd_r == wd_limit_lp) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_r;
`endif

`ifndef SYNTHESIS
    // This port cannot serve requests, so any forward traffic aimed at it
    // means the surrounding network is misrouting.
    always @(negedge clk_i) begin
        if (!reset_i && link_in.fwd.v) begin
            $error("bsg_manycore_link_sif_injector: forward request received, port cannot serve requests");
        end
    end
`endif

endmodule
